decode_unit: RTL and testbench

Instruction decode stage of the 16-bit pipelined processor. It sits directly upstream of the register file. It accepts one instruction word per cycle from fetch and produces registered register-file controls: read addresses, write address, `src_selection`, `mem_write` and `reg_write`, plus ALU op and valid. A per-register scoreboard of in-flight writes stalls fetch, inserting bubbles, until every source operand has been written back.

---
 rtl/decode_unit.sv | 135 +++++++++++++
 tb/tb_decode_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// Instruction decode stage: registers register-file controls for one instruction per cycle
// and stalls fetch through a per-register scoreboard of pending writebacks.
module decode_unit #(
  parameter int WB_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  read_addr1,
  output logic [2:0]  read_addr2,
  output logic [2:0]  write_addr,
  output logic        reg_write,
  output logic        mem_write,
  output logic        src_selection,
  output logic [1:0]  alu_op,
  output logic        valid_out,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic {RUN, HALT} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt [8];

  logic [3:0] opcode_p0;
  logic [2:0] rd_p0, rs_p0, rt_p0;
  logic       use_rs_p0, use_rt_p0;
  logic       reg_write_p0, mem_write_p0, src_sel_p0;
  logic       halt_p0, illegal_p0;
  logic [1:0] alu_op_p0;
  logic       hazard_p0;
  logic       accept_p0;

  assign opcode_p0 = instr[15:12];
  assign rd_p0     = instr[11:9];
  assign rs_p0     = instr[8:6];
  assign rt_p0     = instr[5:3];

  // Stage p0: combinational decode of the presented word
  always_comb begin
    use_rs_p0    = 1'b0;
    use_rt_p0    = 1'b0;
    reg_write_p0 = 1'b0;
    mem_write_p0 = 1'b0;
    src_sel_p0   = 1'b0;
    halt_p0      = 1'b0;
    illegal_p0   = 1'b0;
    alu_op_p0    = 2'b00;
    case (opcode_p0)
      4'd0: ;
      4'd1, 4'd2, 4'd3, 4'd4: begin
        use_rs_p0    = 1'b1;
        use_rt_p0    = 1'b1;
        reg_write_p0 = 1'b1;
        alu_op_p0    = 2'(opcode_p0 - 4'd1);
      end
      4'd5: begin
        use_rs_p0    = 1'b1;
        reg_write_p0 = 1'b1;
        src_sel_p0   = 1'b1;
      end
      4'd6: begin
        use_rs_p0    = 1'b1;
        reg_write_p0 = 1'b1;
      end
      4'd7: begin
        use_rs_p0    = 1'b1;
        use_rt_p0    = 1'b1;
        mem_write_p0 = 1'b1;
      end
      4'd8:    halt_p0    = 1'b1;
      default: illegal_p0 = 1'b1;
    endcase
  end

  assign hazard_p0 = (use_rs_p0 && (cnt[rs_p0] != 3'd0)) ||
                     (use_rt_p0 && (cnt[rt_p0] != 3'd0));

  always_comb begin
    state_d     = state_q;
    instr_ready = (state_q == RUN) && !hazard_p0;
    accept_p0   = instr_valid && instr_ready;
    if (accept_p0 && halt_p0) state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Writeback countdown per register; a fresh load wins over the decrement
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset)
        cnt[i] <= 3'd0;
      else if (accept_p0 && reg_write_p0 && (rd_p0 == 3'(i)))
        cnt[i] <= 3'(WB_LAT);
      else if (cnt[i] != 3'd0)
        cnt[i] <= cnt[i] - 3'd1;
    end
  end

  // Stage p1: registered controls; bubbles keep addresses and alu_op
  always_ff @(posedge clk) begin
    if (reset) begin
      read_addr1    <= 3'd0;
      read_addr2    <= 3'd0;
      write_addr    <= 3'd0;
      alu_op        <= 2'b00;
      reg_write     <= 1'b0;
      mem_write     <= 1'b0;
      src_selection <= 1'b0;
      valid_out     <= 1'b0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      valid_out     <= accept_p0;
      reg_write     <= accept_p0 && reg_write_p0;
      mem_write     <= accept_p0 && mem_write_p0;
      src_selection <= accept_p0 && src_sel_p0;
      halted        <= (state_d == HALT);
      if (accept_p0 && illegal_p0) illegal <= 1'b1;
      if (accept_p0) begin
        read_addr1 <= rs_p0;
        read_addr2 <= rt_p0;
        write_addr <= rd_p0;
        alu_op     <= alu_op_p0;
      end
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: a cycle-level reference model predicts every registered
// output and instr_ready; a monitor pops predictions and compares at the falling edge.
module tb_decode_unit;
  localparam int WB_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  read_addr1, read_addr2, write_addr;
  logic        reg_write, mem_write, src_selection;
  logic [1:0]  alu_op;
  logic        valid_out, halted, illegal;

  decode_unit #(.WB_LAT(WB_LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .write_addr(write_addr), .reg_write(reg_write), .mem_write(mem_write),
    .src_selection(src_selection), .alu_op(alu_op), .valid_out(valid_out),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, rw, mw, ss, hl, il;
    logic [1:0] alu;
    logic [2:0] ra1, ra2, wa;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state
  int         busy_until [8];
  int         cyc = 0;
  logic       halted_m = 1'b0, illegal_m = 1'b0;
  logic [2:0] ra1_m = 0, ra2_m = 0, wa_m = 0;
  logic [1:0] alu_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic uses_rs(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    return ((op >= 4'd1) && (op <= 4'd4)) || (op == 4'd7);
  endfunction

  function automatic logic model_ready(input logic [15:0] ins);
    logic [3:0] op;
    int rs, rt;
    op = ins[15:12];
    rs = int'(ins[8:6]);
    rt = int'(ins[5:3]);
    if (halted_m) return 1'b0;
    if (uses_rs(op) && cyc < busy_until[rs]) return 1'b0;
    if (uses_rt(op) && cyc < busy_until[rt]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one rising edge and queue the expected outputs.
  task automatic model_edge(input logic rst, input logic v, input logic [15:0] ins);
    exp_t e;
    logic [3:0] op;
    logic acc;
    op = ins[15:12];
    e = '0;
    if (rst) begin
      for (int i = 0; i < 8; i++) busy_until[i] = 0;
      halted_m = 0; illegal_m = 0;
      ra1_m = 0; ra2_m = 0; wa_m = 0; alu_m = 0;
    end else begin
      acc = v && model_ready(ins);
      if (acc) begin
        e.v = 1'b1;
        ra1_m = ins[8:6]; ra2_m = ins[5:3]; wa_m = ins[11:9];
        alu_m = (op >= 4'd1 && op <= 4'd4) ? 2'(op - 4'd1) : 2'b00;
        e.rw = (op >= 4'd1 && op <= 4'd6);
        e.mw = (op == 4'd7);
        e.ss = (op == 4'd5);
        if (op == 4'd8) halted_m = 1'b1;
        if (op >= 4'd9) illegal_m = 1'b1;
        if (e.rw) busy_until[int'(ins[11:9])] = cyc + WB_LAT + 1;
      end
    end
    e.ra1 = ra1_m; e.ra2 = ra2_m; e.wa = wa_m; e.alu = alu_m;
    e.hl = halted_m; e.il = illegal_m;
    q.push_back(e);
    cyc++;
  endtask

  // One cycle: present inputs, check instr_ready, clock, update model.
  task automatic step(input logic rst, input logic v, input logic [15:0] ins);
    logic er;
    reset = rst; instr_valid = v; instr = ins;
    er = model_ready(ins);
    #1;
    if (!rst) chk("instr_ready", int'(instr_ready), int'(er));
    @(posedge clk);
    model_edge(rst, v, ins);
    #1;
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("valid_out",     int'(valid_out),     int'(e.v));
        chk("reg_write",     int'(reg_write),     int'(e.rw));
        chk("mem_write",     int'(mem_write),     int'(e.mw));
        chk("src_selection", int'(src_selection), int'(e.ss));
        chk("alu_op",        int'(alu_op),        int'(e.alu));
        chk("read_addr1",    int'(read_addr1),    int'(e.ra1));
        chk("read_addr2",    int'(read_addr2),    int'(e.ra2));
        chk("write_addr",    int'(write_addr),    int'(e.wa));
        chk("halted",        int'(halted),        int'(e.hl));
        chk("illegal",       int'(illegal),       int'(e.il));
      end
    end
  end

  initial begin
    int op, tmo;
    logic v;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    for (int i = 0; i < 8; i++) busy_until[i] = 0;
    @(posedge clk); #1;
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    // ADD r1,r2,r3 then dependent SUB r4,r1,r5 held valid
    step(0, 1, 16'h1298);
    for (int i = 0; i < 4; i++) step(0, 1, mk(2, 4, 1, 5));
    step(0, 0, 16'h0000);
    // independent MOV r2,r6 and STD r6,r7
    step(0, 1, mk(5, 2, 6, 0));
    step(0, 1, mk(7, 0, 6, 7));
    // WAW and self-dependency
    step(0, 1, mk(1, 3, 4, 4));
    step(0, 1, mk(2, 3, 5, 5));
    step(0, 1, mk(1, 6, 6, 6));
    step(0, 1, mk(1, 6, 6, 6));
    for (int i = 0; i < 4; i++) step(0, 1, mk(1, 6, 6, 6));
    // illegal opcode sticky, then reset
    step(0, 1, 16'hC000);
    step(0, 1, mk(3, 1, 2, 2));
    step(0, 1, mk(0, 0, 0, 0));
    step(1, 1, mk(1, 1, 2, 2));
    // HLT, bubbles while halted, reset, then ADD
    step(0, 1, mk(8, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(0, 1, mk(1, 1, 2, 3));
    step(1, 0, 16'h0000);
    step(0, 1, 16'h1298);
    // LDM r3, dependent ADD r0,r3,r3 stalls, reset mid-stall, ADD accepted at once
    step(0, 1, mk(6, 3, 4, 0));
    step(0, 1, mk(1, 0, 3, 3));
    step(0, 1, mk(1, 0, 3, 3));
    step(1, 1, mk(1, 0, 3, 3));
    step(0, 1, mk(1, 0, 3, 3));
    // randomized traffic on a narrow register set to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 15);
      if (op == 8 && $urandom_range(0, 3) != 0) op = 1;
      v = ($urandom_range(0, 9) != 0);
      step(($urandom_range(0, 59) == 0), v,
           mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
    end
    step(0, 0, 16'h0000);
    tmo = 0;
    while (q.size() != 0 && tmo < 10) begin
      @(posedge clk);
      tmo++;
    end
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
